// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU operation issuer: ALU control codes,
// MIPS opcode/funct values, FSM state and operand-select encodings.
package alu_pkg;

  localparam logic [3:0] CTRL_ADD = 4'd0;
  localparam logic [3:0] CTRL_LW  = 4'd1;
  localparam logic [3:0] CTRL_SW  = 4'd2;
  localparam logic [3:0] CTRL_AND = 4'd3;
  localparam logic [3:0] CTRL_NOR = 4'd4;
  localparam logic [3:0] CTRL_SLL = 4'd5;
  localparam logic [3:0] CTRL_BEQ = 4'd6;
  localparam logic [3:0] CTRL_SLT = 4'd7;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  typedef enum logic [1:0] {SEL_RS_RT, SEL_RS_IMM, SEL_RT_SHAMT} opsel_t;

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational MIPS opcode/funct decode into ALU control code, operand
// selection and a legality flag.
module alu_op_decoder
  import alu_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] ctrl,
  output opsel_t     sel,
  output logic       legal
);

  always_comb begin
    ctrl  = CTRL_ADD;
    sel   = SEL_RS_RT;
    legal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        legal = 1'b1;
        case (funct)
          FN_ADD:  ctrl = CTRL_ADD;
          FN_AND:  ctrl = CTRL_AND;
          FN_NOR:  ctrl = CTRL_NOR;
          FN_SLT:  ctrl = CTRL_SLT;
          FN_SLL: begin
            ctrl = CTRL_SLL;
            sel  = SEL_RT_SHAMT;
          end
          default: legal = 1'b0;
        endcase
      end
      OP_ADDI: begin
        legal = 1'b1;
        ctrl  = CTRL_ADD;
        sel   = SEL_RS_IMM;
      end
      // sw rides on the lw code: the ALU does not refresh its output on code 2
      OP_LW, OP_SW: begin
        legal = 1'b1;
        ctrl  = CTRL_LW;
        sel   = SEL_RS_IMM;
      end
      OP_BEQ: begin
        legal = 1'b1;
        ctrl  = CTRL_BEQ;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_op_issuer.sv
// Issues one decoded operation at a time into a combinational ALU and returns
// the captured result on a valid/ready handshake. Optional op counter: ALU_OP_ISSUER_PERF_CNT_EN.
//
// state | meaning
// IDLE  | ready for a request; operand registers hold the last op
// ISSUE | operands driven for one full cycle while the ALU settles
// DONE  | result presented, waiting for res_ready
module alu_op_issuer
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
`ifdef ALU_OP_ISSUER_PERF_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic [4:0]       shamt,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic [15:0]      imm,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_zero,
  output logic             res_illegal
`ifdef ALU_OP_ISSUER_PERF_CNT_EN
  , output logic [CNT_W-1:0] op_count
`endif
);

  state_t           state, state_nxt;
  logic [3:0]       dec_ctrl;
  opsel_t           dec_sel;
  logic             dec_legal;
  logic [WIDTH-1:0] op1, op2;

  alu_op_decoder u_dec (
    .opcode (opcode),
    .funct  (funct),
    .ctrl   (dec_ctrl),
    .sel    (dec_sel),
    .legal  (dec_legal)
  );

  always_comb begin
    op1 = rs_val;
    op2 = rt_val;
    case (dec_sel)
      SEL_RS_IMM:   op2 = {{(WIDTH-16){imm[15]}}, imm};
      SEL_RT_SHAMT: begin
        op1 = rt_val;
        op2 = {{(WIDTH-5){1'b0}}, shamt};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = dec_legal ? ISSUE : DONE;
      ISSUE:   state_nxt = DONE;
      DONE:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // in_ready is masked by reset so every output reads 0 while reset is held
  always_comb begin
    in_ready  = (state == IDLE) && !reset;
    res_valid = (state == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_in1     <= '0;
      alu_in2     <= '0;
      alu_ctrl    <= '0;
      res_data    <= '0;
      res_zero    <= 1'b0;
      res_illegal <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          if (dec_legal) begin
            alu_in1  <= op1;
            alu_in2  <= op2;
            alu_ctrl <= dec_ctrl;
          end else begin
            res_illegal <= 1'b1;
            res_data    <= '0;
            res_zero    <= 1'b0;
          end
        end
        // beq compares locally: the ALU leaves its zero flag stale when unequal
        ISSUE: begin
          res_data <= alu_out;
          res_zero <= (alu_ctrl == CTRL_BEQ) ? (alu_in1 == alu_in2) : alu_zero;
        end
        DONE: if (res_ready) res_illegal <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef ALU_OP_ISSUER_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_count <= '0;
    end else if (state == DONE && res_ready && !res_illegal && op_count != '1) begin
      op_count <= op_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_alu_op_issuer.sv
// Directed self-checking bench for alu_op_issuer with a behavioural ALU responder
// whose zero flag can be forced stale. Define ALU_OP_ISSUER_PERF_CNT_EN to cover op_count.
module tb_alu_op_issuer;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid, in_ready;
  logic [5:0]       opcode, funct;
  logic [4:0]       shamt;
  logic [WIDTH-1:0] rs_val, rt_val;
  logic [15:0]      imm;
  logic [WIDTH-1:0] alu_in1, alu_in2, alu_out;
  logic [3:0]       alu_ctrl;
  logic             alu_zero;
  logic             res_valid, res_ready, res_zero, res_illegal;
  logic [WIDTH-1:0] res_data;
  logic             stale_zero;
  int               tests = 0;
  int               fails = 0;
`ifdef ALU_OP_ISSUER_PERF_CNT_EN
  logic [1:0]       op_count;
`endif

  always #5 clk = ~clk;

  alu_op_issuer #(
    .WIDTH (WIDTH)
`ifdef ALU_OP_ISSUER_PERF_CNT_EN
    , .CNT_W (2)
`endif
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .opcode      (opcode),
    .funct       (funct),
    .shamt       (shamt),
    .rs_val      (rs_val),
    .rt_val      (rt_val),
    .imm         (imm),
    .alu_in1     (alu_in1),
    .alu_in2     (alu_in2),
    .alu_ctrl    (alu_ctrl),
    .alu_out     (alu_out),
    .alu_zero    (alu_zero),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_zero    (res_zero),
    .res_illegal (res_illegal)
`ifdef ALU_OP_ISSUER_PERF_CNT_EN
    , .op_count  (op_count)
`endif
  );

  // Responder ALU; stale_zero mimics the unit leaving Zero set on unequal beq
  always_comb begin
    alu_out = '0;
    case (alu_ctrl)
      4'd0, 4'd1, 4'd2: alu_out = alu_in1 + alu_in2;
      4'd3: alu_out = alu_in1 & alu_in2;
      4'd4: alu_out = ~(alu_in1 | alu_in2);
      4'd5: alu_out = alu_in1 << alu_in2[4:0];
      4'd6: alu_out = alu_in1 - alu_in2;
      4'd7: alu_out = {31'd0, $signed(alu_in1) < $signed(alu_in2)};
      default: alu_out = '0;
    endcase
    alu_zero = stale_zero ? 1'b1 : (alu_out == '0);
  end

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present a request at a negedge; returns at the negedge after the accept edge
  task automatic send(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                      input logic [WIDTH-1:0] rs, input logic [WIDTH-1:0] rt, input logic [15:0] im);
    opcode = op; funct = fn; shamt = sh; rs_val = rs; rt_val = rt; imm = im;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic ack();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; res_ready = 1'b0; stale_zero = 1'b0;
    opcode = '0; funct = '0; shamt = '0; rs_val = '0; rt_val = '0; imm = '0;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 0);
    chk("rst_res_valid", {31'd0, res_valid}, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_alu_in1", alu_in1, 0);
    chk("rst_alu_ctrl", {28'd0, alu_ctrl}, 0);
    chk("rst_res_illegal", {31'd0, res_illegal}, 0);
    reset = 1'b0;
    #1 chk("idle_in_ready", {31'd0, in_ready}, 1);
    @(negedge clk);

    // add 5+7: one edge after accept the operands are up, valid after the second
    send(6'h00, 6'h20, 5'd0, 32'd5, 32'd7, 16'h0);
    chk("add_valid_e1", {31'd0, res_valid}, 0);
    chk("add_in_ready_e1", {31'd0, in_ready}, 0);
    chk("add_ctrl", {28'd0, alu_ctrl}, 0);
    chk("add_in1", alu_in1, 5);
    chk("add_in2", alu_in2, 7);
    tick();
    chk("add_valid_e2", {31'd0, res_valid}, 1);
    chk("add_data", res_data, 12);
    chk("add_zero", {31'd0, res_zero}, 0);
    ack();
    chk("add_valid_clr", {31'd0, res_valid}, 0);
    chk("add_idle", {31'd0, in_ready}, 1);

    send(6'h04, 6'h00, 5'd0, 32'd3, 32'd3, 16'h0);
    tick();
    chk("beq_eq_ctrl", {28'd0, alu_ctrl}, 6);
    chk("beq_eq_zero", {31'd0, res_zero}, 1);
    chk("beq_eq_data", res_data, 0);
    ack();

    stale_zero = 1'b1;
    send(6'h04, 6'h00, 5'd0, 32'd3, 32'd4, 16'h0);
    tick();
    chk("beq_ne_zero", {31'd0, res_zero}, 0);
    chk("beq_ne_data", res_data, 32'hFFFF_FFFF);
    stale_zero = 1'b0;
    ack();

    send(6'h00, 6'h00, 5'd4, 32'd9, 32'd1, 16'h0);
    chk("sll_in1", alu_in1, 1);
    chk("sll_in2", alu_in2, 4);
    chk("sll_ctrl", {28'd0, alu_ctrl}, 5);
    tick();
    chk("sll_data", res_data, 16);
    ack();

    send(6'h23, 6'h00, 5'd0, 32'h100, 32'd0, 16'hFFFC);
    chk("lw_ctrl", {28'd0, alu_ctrl}, 1);
    chk("lw_in2", alu_in2, 32'hFFFF_FFFC);
    tick();
    chk("lw_data", res_data, 32'hFC);
    ack();

    send(6'h2B, 6'h00, 5'd0, 32'h10, 32'd0, 16'h0004);
    chk("sw_ctrl", {28'd0, alu_ctrl}, 1);
    tick();
    chk("sw_data", res_data, 32'h14);
    ack();

    send(6'h08, 6'h00, 5'd0, 32'd10, 32'd0, 16'hFFFF);
    tick();
    chk("addi_data", res_data, 9);
    ack();

    send(6'h00, 6'h27, 5'd0, 32'd0, 32'hF0, 16'h0);
    tick();
    chk("nor_data", res_data, 32'hFFFF_FF0F);
    ack();

    send(6'h00, 6'h24, 5'd0, 32'hFF00, 32'h0FF0, 16'h0);
    tick();
    chk("and_data", res_data, 32'h0F00);
    ack();

    send(6'h00, 6'h2A, 5'd0, 32'hFFFF_FFFF, 32'd1, 16'h0);
    tick();
    chk("slt_ctrl", {28'd0, alu_ctrl}, 7);
    chk("slt_data", res_data, 1);
    ack();

    // illegal op: straight to DONE, ALU registers untouched (ctrl stays 7)
    send(6'h3F, 6'h00, 5'd0, 32'd1, 32'd1, 16'h0);
    chk("ill_valid", {31'd0, res_valid}, 1);
    chk("ill_flag", {31'd0, res_illegal}, 1);
    chk("ill_data", res_data, 0);
    chk("ill_zero", {31'd0, res_zero}, 0);
    chk("ill_ctrl", {28'd0, alu_ctrl}, 7);
    ack();
    chk("ill_flag_clr", {31'd0, res_illegal}, 0);
    chk("ill_valid_clr", {31'd0, res_valid}, 0);

    // backpressure with a competing request held on in_valid
    send(6'h00, 6'h20, 5'd0, 32'd1, 32'd2, 16'h0);
    tick();
    opcode = 6'h00; funct = 6'h20; rs_val = 32'd100; rt_val = 32'd200;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", {31'd0, res_valid}, 1);
      chk("bp_data", res_data, 3);
      chk("bp_in_ready", {31'd0, in_ready}, 0);
    end
    in_valid = 1'b0;
    ack();
    chk("bp_no_accept", alu_in1, 1);
    chk("bp_idle", {31'd0, in_ready}, 1);

    // reset while in ISSUE
    send(6'h00, 6'h20, 5'd0, 32'd5, 32'd7, 16'h0);
    reset = 1'b1;
    #1;
    chk("midrst_valid", {31'd0, res_valid}, 0);
    chk("midrst_in1", alu_in1, 0);
    chk("midrst_ctrl", {28'd0, alu_ctrl}, 0);
    chk("midrst_data", res_data, 0);
    chk("midrst_in_ready", {31'd0, in_ready}, 0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk("postrst_idle", {31'd0, in_ready}, 1);
    chk("postrst_valid", {31'd0, res_valid}, 0);
    send(6'h00, 6'h20, 5'd0, 32'd2, 32'd2, 16'h0);
    tick();
    chk("postrst_data", res_data, 4);
    ack();

`ifdef ALU_OP_ISSUER_PERF_CNT_EN
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("cnt_rst", {30'd0, op_count}, 0);
    send(6'h3F, 6'h00, 5'd0, 32'd0, 32'd0, 16'h0);
    ack();
    chk("cnt_illegal", {30'd0, op_count}, 0);
    send(6'h00, 6'h20, 5'd0, 32'd1, 32'd1, 16'h0);
    tick();
    ack();
    chk("cnt_one", {30'd0, op_count}, 1);
    for (int i = 0; i < 4; i++) begin
      send(6'h00, 6'h20, 5'd0, 32'd1, 32'd1, 16'h0);
      tick();
      ack();
    end
    chk("cnt_sat", {30'd0, op_count}, 3);
    send(6'h3F, 6'h00, 5'd0, 32'd0, 32'd0, 16'h0);
    ack();
    chk("cnt_sat_ill", {30'd0, op_count}, 3);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
